tx_dac_serializer: RTL and testbench



---
 rtl/tx_dac_serializer.sv | 148 ++++++++++++++
 tb/tb_tx_dac_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_dac_serializer.sv
// tx_dac_serializer: 2-entry FIFO feeding an LSB-first 8-lane serializer with divided memory clock and frame marker.
// Optional PRBS7 lane source when TX_DAC_PRBS_EN is defined.
module tx_dac_serializer #(
    parameter int WORD_W = 128,
    parameter int LANES = 8,
    parameter logic [LANES-1:0] IDLE_PAT = '0
) (
    input  logic              tx_dac_2400MHz_clk,
    input  logic              TX_DAC_RST_ACTLOW,
    input  logic              tx_en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              prbs_mode,
    output logic [LANES-1:0]  TX_DAC_DIG_OUT,
    output logic              tx_dac_frame_out,
    output logic              tx_dac_mem_clk_out,
    output logic              tx_dac_busy,
    output logic [15:0]       tx_dac_underflow_cnt
);
    localparam int BEATS = WORD_W / LANES;
    localparam int BW = $clog2(BEATS + 1);
    localparam int DW = $clog2(BEATS / 2);

`ifdef TX_DAC_PRBS_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PRBS} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t state, state_d;
    logic [WORD_W-1:0] fifo_mem [2];
    logic wr_ptr, rd_ptr, push, pop, underflow;
    logic [1:0] count;
    logic [WORD_W-1:0] shift_reg, shift_d;
    logic [BW-1:0] beat, beat_d;
    logic [LANES-1:0] dig_d;
    logic frame_d;
    logic [DW-1:0] div_cnt;

    assign in_ready = TX_DAC_RST_ACTLOW && count != 2'd2;
    assign push = in_valid && in_ready;
    assign tx_dac_busy = state == SHIFT;

    always_ff @(posedge tx_dac_2400MHz_clk)
        if (push)
            fifo_mem[wr_ptr] <= in_data;

    always_ff @(posedge tx_dac_2400MHz_clk) begin
        if (!TX_DAC_RST_ACTLOW) begin
            count <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count <= count + 2'(push) - 2'(pop);
        end
    end

`ifdef TX_DAC_PRBS_EN
    logic [6:0] prbs, prbs_d, prbs_next;
    logic [LANES-1:0] prbs_bits;
    // x^7+x^6+1 stepped LANES times; the first generated bit lands on lane 0
    always_comb begin
        prbs_next = prbs;
        prbs_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            prbs_bits[i] = prbs_next[6] ^ prbs_next[5];
            prbs_next = {prbs_next[5:0], prbs_bits[i]};
        end
    end
    always_ff @(posedge tx_dac_2400MHz_clk)
        prbs <= !TX_DAC_RST_ACTLOW ? 7'h7F : prbs_d;
`else
    logic prbs_unused;
    assign prbs_unused = prbs_mode;
`endif

    always_comb begin
        state_d = state;
        shift_d = shift_reg;
        beat_d = beat;
        dig_d = IDLE_PAT;
        frame_d = 1'b0;
        pop = 1'b0;
        underflow = 1'b0;
`ifdef TX_DAC_PRBS_EN
        prbs_d = prbs;
`endif
        if (state == SHIFT && beat != BW'(BEATS)) begin
            dig_d = shift_reg[LANES-1:0];
            shift_d = shift_reg >> LANES;
            beat_d = beat + BW'(1);
        end
`ifdef TX_DAC_PRBS_EN
        else if (tx_en && prbs_mode) begin
            state_d = PRBS;
            dig_d = prbs_bits;
            prbs_d = prbs_next;
        end
`endif
        else if (tx_en && count != 2'd0) begin
            state_d = SHIFT;
            pop = 1'b1;
            dig_d = fifo_mem[rd_ptr][LANES-1:0];
            shift_d = fifo_mem[rd_ptr] >> LANES;
            frame_d = 1'b1;
            beat_d = BW'(1);
        end else begin
            state_d = IDLE;
            beat_d = '0;
            underflow = tx_en && state == SHIFT;
        end
    end

    always_ff @(posedge tx_dac_2400MHz_clk) begin
        if (!TX_DAC_RST_ACTLOW) begin
            state <= IDLE;
            shift_reg <= '0;
            beat <= '0;
            TX_DAC_DIG_OUT <= IDLE_PAT;
            tx_dac_frame_out <= 1'b0;
            tx_dac_underflow_cnt <= '0;
        end else begin
            state <= state_d;
            shift_reg <= shift_d;
            beat <= beat_d;
            TX_DAC_DIG_OUT <= dig_d;
            tx_dac_frame_out <= frame_d;
            if (underflow && tx_dac_underflow_cnt != 16'hFFFF)
                tx_dac_underflow_cnt <= tx_dac_underflow_cnt + 16'd1;
        end
    end

    // free-running divider: one memory-clock period per word time
    always_ff @(posedge tx_dac_2400MHz_clk) begin
        if (!TX_DAC_RST_ACTLOW) begin
            div_cnt <= '0;
            tx_dac_mem_clk_out <= 1'b0;
        end else if (div_cnt == DW'(BEATS / 2 - 1)) begin
            div_cnt <= '0;
            tx_dac_mem_clk_out <= ~tx_dac_mem_clk_out;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end
endmodule

// File: tb/tb_tx_dac_serializer.sv
// tb_tx_dac_serializer: word-position reference model checked every cycle plus directed literal checks.
module tb_tx_dac_serializer;
    localparam int BEATS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_en = 1'b0;
    logic [127:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic prbs_mode = 1'b0;
    logic [7:0] dig;
    logic frame, mclk, busy;
    logic [15:0] ufc;

    int total = 0;
    int bad = 0;
    bit chk = 1'b0;

    tx_dac_serializer dut (
        .tx_dac_2400MHz_clk(clk),
        .TX_DAC_RST_ACTLOW(rst_n),
        .tx_en(tx_en),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .prbs_mode(prbs_mode),
        .TX_DAC_DIG_OUT(dig),
        .tx_dac_frame_out(frame),
        .tx_dac_mem_clk_out(mclk),
        .tx_dac_busy(busy),
        .tx_dac_underflow_cnt(ufc)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of accepted words, the word on the lanes and which byte of it is showing.
    logic [127:0] q[$];
    logic [127:0] cur = '0;
    int pos = -1;
    int m_uf = 0;
    int tick = 0;
    bit acc;
    logic [7:0] exp_dig;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            pos = -1;
            m_uf = 0;
            tick = 0;
        end else begin
            acc = in_valid && q.size() < 2;
            if (pos >= 0 && pos < BEATS - 1)
                pos++;
            else if (tx_en && q.size() > 0) begin
                cur = q.pop_front();
                pos = 0;
            end else begin
                if (pos == BEATS - 1 && tx_en && m_uf < 65535)
                    m_uf++;
                pos = -1;
            end
            if (acc)
                q.push_back(in_data);
            tick++;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            exp_dig = 8'h00;
            if (pos >= 0)
                exp_dig = cur[pos*8 +: 8];
            check("m_dig", dig, exp_dig);
            check("m_frame", frame, pos == 0);
            check("m_busy", busy, pos >= 0);
            check("m_mclk", mclk, (tick / 8) % 2);
            check("m_uf", ufc, m_uf);
            check("m_ready", in_ready, rst_n && q.size() < 2);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [127:0] w);
        bit a;
        int n;
        in_data = w;
        in_valid = 1'b1;
        n = 0;
        do begin
            a = in_ready;
            step(1);
            n++;
        end while (!a && n < 50);
        check("push_accept", a, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (busy && n < 100);
        check("idle_reached", busy, 0);
    endtask

    function automatic logic [127:0] mkw(input int s);
        logic [127:0] w;
        for (int j = 0; j < 16; j++)
            w[j*8 +: 8] = 8'(s + j * 17);
        return w;
    endfunction

    logic [127:0] w0, w4, w5;

    initial begin
        w0 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        w4 = mkw(8'h40);
        w5 = mkw(8'h50);
        step(1);
        chk = 1'b1;
        check("rst_ready", in_ready, 0);
        step(2);
        rst_n = 1'b1;
        // idle with tx_en low: divider only
        step(7);
        check("idle_dig", dig, 8'h00);
        check("idle_ready", in_ready, 1);
        check("mclk_7", mclk, 0);
        step(1);
        check("mclk_8", mclk, 1);
        step(8);
        check("mclk_16", mclk, 0);
        step(4);
        // single word, underflow after it
        tx_en = 1'b1;
        push_word(w0);
        step(1);
        check("w0_beat0", dig, 8'h00);
        check("w0_frame0", frame, 1);
        check("w0_busy", busy, 1);
        step(1);
        check("w0_beat1", dig, 8'h01);
        check("w0_frame1", frame, 0);
        step(14);
        check("w0_beat15", dig, 8'h0F);
        step(1);
        check("w0_done_busy", busy, 0);
        check("w0_uf", ufc, 16'd1);
        // three words, third stalls until first pop
        tx_en = 1'b0;
        push_word(mkw(8'h10));
        push_word(mkw(8'h20));
        check("full_ready", in_ready, 0);
        tx_en = 1'b1;
        push_word(mkw(8'h30));
        wait_idle();
        check("three_uf", ufc, 16'd2);
        // drop tx_en mid-word with a second word queued
        tx_en = 1'b0;
        push_word(w4);
        push_word(w5);
        tx_en = 1'b1;
        step(6);
        check("w4_beat5", dig, w4[47:40]);
        tx_en = 1'b0;
        step(11);
        check("drop_busy", busy, 0);
        check("drop_uf", ufc, 16'd2);
        check("drop_ready", in_ready, 1);
        step(3);
        tx_en = 1'b1;
        step(1);
        check("w5_beat0", dig, w5[7:0]);
        check("w5_frame", frame, 1);
        wait_idle();
        check("w5_uf", ufc, 16'd3);
        // reset mid-word with two queued
        tx_en = 1'b0;
        push_word(mkw(8'h60));
        push_word(mkw(8'h70));
        tx_en = 1'b1;
        push_word(mkw(8'h80));
        step(8);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        step(1);
        check("rst_dig", dig, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_mclk", mclk, 0);
        check("rst_uf", ufc, 16'd0);
        check("rst_ready0", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rst_ready1", in_ready, 1);
        step(7);
        check("rst_empty_dig", dig, 8'h00);
        check("rst_mclk7", mclk, 0);
        step(1);
        check("rst_mclk8", mclk, 1);
`ifdef TX_DAC_PRBS_EN
        begin
            bit b[$];
            logic [7:0] pb;
            chk = 1'b0;
            for (int i = 0; i < 7; i++)
                b.push_back(1'b1);
            for (int n = 7; n < 7 + 8 * 40; n++)
                b.push_back(b[n-7] ^ b[n-6]);
            rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
            prbs_mode = 1'b1;
            for (int k = 0; k < 40; k++) begin
                step(1);
                for (int i = 0; i < 8; i++)
                    pb[i] = b[7 + 8*k + i];
                check("prbs_byte", dig, pb);
                check("prbs_frame", frame, 0);
            end
            prbs_mode = 1'b0;
            tx_en = 1'b0;
            rst_n = 1'b0;
            step(1);
            chk = 1'b1;
            rst_n = 1'b1;
            step(4);
        end
`endif
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
